// File: rtl/sram_arb_pkg.sv
// Shared types and defaults for the SRAM port arbiter (FSM encoding, macro geometry).
package sram_arb_pkg;

  localparam int unsigned SRAM_AW      = 13;
  localparam int unsigned SRAM_DW      = 32;
  localparam int unsigned SRAM_BW      = SRAM_DW / 8;
  localparam logic [3:0]  WEN_IDLE     = 4'hF;
  localparam int unsigned DRAIN_CYCLES = 2;

  typedef enum logic [1:0] {
    ST_FUNC  = 2'd0,
    ST_DRAIN = 2'd1,
    ST_BIST  = 2'd2
  } arb_state_e;

endpackage

// File: rtl/sram_arb_rr.sv
// 2-way round-robin picker: one-hot grant from req, pointer remembers the last winner.
module sram_arb_rr (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic [1:0] req,
  output logic [1:0] gnt
);

  // last_q=1 means port1 won last, so port0 wins the next tie
  logic last_q;

  always_comb begin
    gnt = '0;
    if (en) begin
      if (req == 2'b11) begin
        gnt = last_q ? 2'b01 : 2'b10;
      end else begin
        gnt = req;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_q <= 1'b1;
    end else if (gnt[0]) begin
      last_q <= 1'b0;
    end else if (gnt[1]) begin
      last_q <= 1'b1;
    end
  end

endmodule

// File: rtl/sram_port_arbiter.sv
// Shares a single-port SRAM macro between two round-robin functional ports and BIST.
// Optional performance counters are built when SRAM_ARB_PERF_EN is defined.
module sram_port_arbiter
  import sram_arb_pkg::*;
#(
  parameter int unsigned AW = SRAM_AW,
  parameter int unsigned DW = SRAM_DW,
  parameter int unsigned BW = SRAM_BW
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          req0,
  input  logic          req1,
  input  logic          we0,
  input  logic          we1,
  input  logic [BW-1:0] be0,
  input  logic [BW-1:0] be1,
  input  logic [AW-1:0] addr0,
  input  logic [AW-1:0] addr1,
  input  logic [DW-1:0] wdata0,
  input  logic [DW-1:0] wdata1,
  output logic          gnt0,
  output logic          gnt1,
  output logic          rvalid0,
  output logic          rvalid1,
  output logic [DW-1:0] rdata,
  input  logic          bist_mode,
  output logic          bist_ready,
  input  logic          bist_cen,
  input  logic [BW-1:0] bist_wen,
  input  logic [AW-1:0] bist_addr,
  input  logic [DW-1:0] bist_d,
  output logic          mem_cen,
  output logic [BW-1:0] mem_wen,
  output logic [AW-1:0] mem_a,
  output logic [DW-1:0] mem_d,
  output logic          mem_oen,
  input  logic [DW-1:0] mem_q
`ifdef SRAM_ARB_PERF_EN
  ,
  output logic [15:0]   gnt_cnt0,
  output logic [15:0]   gnt_cnt1,
  output logic [15:0]   conflict_cnt
`endif
);

  localparam logic [BW-1:0] WEN_OFF = {BW{WEN_IDLE[0]}};

  arb_state_e state_q, state_d;
  logic [1:0] drain_cnt_q;
  logic       grant_en;
  logic       bist_own;

  always_comb begin
    state_d  = state_q;
    grant_en = 1'b0;
    bist_own = 1'b0;
    unique case (state_q)
      ST_FUNC: begin
        if (bist_mode) state_d = ST_DRAIN;
        else           grant_en = 1'b1;
      end
      ST_DRAIN: begin
        if (drain_cnt_q == 2'(DRAIN_CYCLES - 1)) begin
          state_d = bist_mode ? ST_BIST : ST_FUNC;
        end
      end
      ST_BIST: begin
        // Release cycle leaves the macro idle from the command register
        if (bist_mode) bist_own = 1'b1;
        else           state_d  = ST_FUNC;
      end
      default: state_d = ST_FUNC;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_FUNC;
      drain_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      drain_cnt_q <= (state_q == ST_DRAIN) ? drain_cnt_q + 2'd1 : '0;
    end
  end

  logic [1:0] gnt_v;

  sram_arb_rr u_rr (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (grant_en),
    .req   ({req1, req0}),
    .gnt   (gnt_v)
  );

  assign gnt0 = gnt_v[0];
  assign gnt1 = gnt_v[1];

  logic          sel_we;
  logic [BW-1:0] sel_be;
  logic [AW-1:0] sel_addr;
  logic [DW-1:0] sel_wdata;

  always_comb begin
    sel_we    = gnt_v[1] ? we1    : we0;
    sel_be    = gnt_v[1] ? be1    : be0;
    sel_addr  = gnt_v[1] ? addr1  : addr0;
    sel_wdata = gnt_v[1] ? wdata1 : wdata0;
  end

  logic          cmd_cen_q;
  logic [BW-1:0] cmd_wen_q;
  logic [AW-1:0] cmd_a_q;
  logic [DW-1:0] cmd_d_q;
  logic [1:0]    rd_p1_q, rd_p2_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cmd_cen_q <= 1'b1;
      cmd_wen_q <= WEN_OFF;
      cmd_a_q   <= '0;
      cmd_d_q   <= '0;
    end else if (|gnt_v) begin
      cmd_cen_q <= 1'b0;
      cmd_a_q   <= sel_addr;
      cmd_d_q   <= sel_wdata;
      cmd_wen_q <= sel_we ? ~sel_be : WEN_OFF;
    end else begin
      cmd_cen_q <= 1'b1;
      cmd_wen_q <= WEN_OFF;
    end
  end

  // Only reads enter the valid pipe; a write with be=0 stays silent
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_p1_q <= '0;
      rd_p2_q <= '0;
    end else begin
      rd_p1_q <= gnt_v & {2{~sel_we}};
      rd_p2_q <= rd_p1_q;
    end
  end

  assign rvalid0    = rd_p2_q[0] & (state_q != ST_BIST);
  assign rvalid1    = rd_p2_q[1] & (state_q != ST_BIST);
  assign rdata      = mem_q;
  assign bist_ready = bist_own;

  always_comb begin
    mem_cen = cmd_cen_q;
    mem_wen = cmd_wen_q;
    mem_a   = cmd_a_q;
    mem_d   = cmd_d_q;
    if (bist_own) begin
      mem_cen = bist_cen;
      mem_wen = bist_wen;
      mem_a   = bist_addr;
      mem_d   = bist_d;
    end
  end

  assign mem_oen = 1'b0;

`ifdef SRAM_ARB_PERF_EN
  logic bist_ready_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bist_ready_q <= 1'b0;
      gnt_cnt0     <= '0;
      gnt_cnt1     <= '0;
      conflict_cnt <= '0;
    end else begin
      bist_ready_q <= bist_ready;
      if (bist_ready && !bist_ready_q) begin
        gnt_cnt0     <= '0;
        gnt_cnt1     <= '0;
        conflict_cnt <= '0;
      end else begin
        if (gnt_v[0] && gnt_cnt0 != 16'hFFFF) gnt_cnt0 <= gnt_cnt0 + 16'd1;
        if (gnt_v[1] && gnt_cnt1 != 16'hFFFF) gnt_cnt1 <= gnt_cnt1 + 16'd1;
        if (state_q == ST_FUNC && req0 && req1 && conflict_cnt != 16'hFFFF)
          conflict_cnt <= conflict_cnt + 16'd1;
      end
    end
  end
`endif

endmodule
